// File: rtl/regfile_pkg.sv
// ============================================================================
// Module      : regfile_pkg
// Description : Shared types and constants for the regfile_obs register file
//               and its serial observation shifter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package regfile_pkg;

    localparam int c_XLEN_DEFAULT  = 32;
    localparam int c_NREGS_DEFAULT = 32;

    typedef enum logic [1:0] {
        OBS_IDLE  = 2'd0,
        OBS_ADDR  = 2'd1,
        OBS_SHIFT = 2'd2
    } obs_state_t;

    // A single-register file still needs one address bit on the ports.
    function automatic int addr_width(input int nregs);
        return (nregs > 1) ? $clog2(nregs) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/regfile_obs_shifter.sv
// ============================================================================
// Module      : obs_shifter
// Description : Serial observation FSM: collects a register address from a
//               1-bit input, snapshots that register and shifts it out MSB
//               first.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module obs_shifter
    import regfile_pkg::*;
#(
    parameter int XLEN = c_XLEN_DEFAULT,
    parameter int AW   = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_sel,
    input  logic [XLEN-1:0] i_rd_data,
    output logic [AW-1:0]   o_rd_addr,
    output logic            o_data,
    output logic            o_valid
);

    localparam int              c_CW          = $clog2(((XLEN > AW) ? XLEN : AW) + 1);
    localparam logic [c_CW-1:0] c_ADDR_LAST   = c_CW'(AW - 1);
    localparam logic [c_CW-1:0] c_SHIFT_LAST  = c_CW'(XLEN - 1);

    obs_state_t      r_state;
    obs_state_t      w_state_next;
    logic [c_CW-1:0] r_cnt;
    logic [XLEN-1:0] r_snap;

    // The read address already includes the bit arriving this cycle, so the
    // snapshot taken on the last address edge sees the complete address.
    if (AW > 1) begin : g_addr_wide
        logic [AW-2:0] r_addr_hi;

        assign o_rd_addr = {r_addr_hi, i_sel};

        always_ff @(posedge clk) begin
            if (rst) begin
                r_addr_hi <= '0;
            end else if (r_state == OBS_ADDR) begin
                r_addr_hi <= o_rd_addr[AW-2:0];
            end
        end
    end else begin : g_addr_narrow
        assign o_rd_addr = i_sel;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= OBS_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            OBS_IDLE:  if (i_sel) w_state_next = OBS_ADDR;
            OBS_ADDR:  if (r_cnt == c_ADDR_LAST) w_state_next = OBS_SHIFT;
            OBS_SHIFT: if (r_cnt == c_SHIFT_LAST) w_state_next = OBS_IDLE;
            default:   w_state_next = OBS_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt  <= '0;
            r_snap <= '0;
        end else begin
            case (r_state)
                OBS_IDLE: begin
                    r_cnt <= '0;
                end
                OBS_ADDR: begin
                    if (r_cnt == c_ADDR_LAST) begin
                        r_cnt  <= '0;
                        r_snap <= i_rd_data;
                    end else begin
                        r_cnt <= r_cnt + c_CW'(1);
                    end
                end
                OBS_SHIFT: begin
                    r_snap <= {r_snap[XLEN-2:0], 1'b0};
                    r_cnt  <= (r_cnt == c_SHIFT_LAST) ? '0 : r_cnt + c_CW'(1);
                end
                default: begin
                    r_cnt <= '0;
                end
            endcase
        end
    end

    always_comb begin
        o_valid = (r_state == OBS_SHIFT);
        o_data  = o_valid & r_snap[XLEN-1];
    end

endmodule

`default_nettype wire

// File: rtl/regfile_obs.sv
// ============================================================================
// Module      : regfile_obs
// Description : Architectural register file, 3 async read ports, 1 write
//               port, r0 hardwired to zero, plus a serial observation port.
//               Optional macro REGFILE_BYPASS_EN forwards write data to reads.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_obs
    import regfile_pkg::*;
#(
    parameter int XLEN  = c_XLEN_DEFAULT,
    parameter int NREGS = c_NREGS_DEFAULT
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [addr_width(NREGS)-1:0] reg1_in,
    input  logic [addr_width(NREGS)-1:0] reg2_in,
    input  logic [addr_width(NREGS)-1:0] reg_source_in,
    input  logic [addr_width(NREGS)-1:0] reg_dest_in,
    input  logic [XLEN-1:0]             data_in,
    input  logic                        reg_wen_in,
    output logic [XLEN-1:0]             data1_out,
    output logic [XLEN-1:0]             data2_out,
    output logic [XLEN-1:0]             source_data_out,
    input  logic                        reg_obs_sel_in,
    output logic                        reg_obs_data_out,
    output logic                        reg_obs_valid_out
);

    localparam int AW = addr_width(NREGS);

    // Register 0 has no storage; it reads as zero by falling through below.
    logic [XLEN-1:0] r_regs [1:NREGS-1];

    logic [XLEN-1:0] w_rd1;
    logic [XLEN-1:0] w_rd2;
    logic [XLEN-1:0] w_rd_src;
    logic [XLEN-1:0] w_rd_obs;
    logic [AW-1:0]   w_obs_addr;
    logic            w_wr_hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 1; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            for (int i = 1; i < NREGS; i++) begin
                if (reg_wen_in && (reg_dest_in == AW'(i))) begin
                    r_regs[i] <= data_in;
                end
            end
        end
    end

    // Addresses of 0 or beyond NREGS never match and so return zero.
    always_comb begin
        w_rd1    = '0;
        w_rd2    = '0;
        w_rd_src = '0;
        w_rd_obs = '0;
        w_wr_hit = 1'b0;
        for (int i = 1; i < NREGS; i++) begin
            if (reg1_in       == AW'(i)) w_rd1    = r_regs[i];
            if (reg2_in       == AW'(i)) w_rd2    = r_regs[i];
            if (reg_source_in == AW'(i)) w_rd_src = r_regs[i];
            if (w_obs_addr    == AW'(i)) w_rd_obs = r_regs[i];
            if (reg_dest_in   == AW'(i)) w_wr_hit = reg_wen_in;
        end
    end

`ifdef REGFILE_BYPASS_EN
    always_comb begin
        data1_out       = (w_wr_hit && (reg1_in       == reg_dest_in)) ? data_in : w_rd1;
        data2_out       = (w_wr_hit && (reg2_in       == reg_dest_in)) ? data_in : w_rd2;
        source_data_out = (w_wr_hit && (reg_source_in == reg_dest_in)) ? data_in : w_rd_src;
    end
`else
    logic w_wr_hit_unused;
    assign w_wr_hit_unused = w_wr_hit;

    always_comb begin
        data1_out       = w_rd1;
        data2_out       = w_rd2;
        source_data_out = w_rd_src;
    end
`endif

    // The observation read bypasses forwarding so snapshots are pre-write.
    obs_shifter #(
        .XLEN (XLEN),
        .AW   (AW)
    ) u_obs_shifter (
        .clk       (clk),
        .rst       (rst),
        .i_sel     (reg_obs_sel_in),
        .i_rd_data (w_rd_obs),
        .o_rd_addr (w_obs_addr),
        .o_data    (reg_obs_data_out),
        .o_valid   (reg_obs_valid_out)
    );

endmodule

`default_nettype wire

// File: tb/tb_regfile_obs.sv
// ============================================================================
// Module      : tb_regfile_obs
// Description : Scoreboard bench for regfile_obs: directed read/write and
//               serial observation frames against hand-computed values.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_regfile_obs;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int AW    = 5;

    logic            clk = 1'b0;
    logic            rst;
    logic [AW-1:0]   reg1_in, reg2_in, reg_source_in, reg_dest_in;
    logic [XLEN-1:0] data_in;
    logic            reg_wen_in;
    logic [XLEN-1:0] data1_out, data2_out, source_data_out;
    logic            reg_obs_sel_in;
    logic            reg_obs_data_out, reg_obs_valid_out;

    always #5 clk = ~clk;

    regfile_obs #(.XLEN(XLEN), .NREGS(NREGS)) dut (
        .clk               (clk),
        .rst               (rst),
        .reg1_in           (reg1_in),
        .reg2_in           (reg2_in),
        .reg_source_in     (reg_source_in),
        .reg_dest_in       (reg_dest_in),
        .data_in           (data_in),
        .reg_wen_in        (reg_wen_in),
        .data1_out         (data1_out),
        .data2_out         (data2_out),
        .source_data_out   (source_data_out),
        .reg_obs_sel_in    (reg_obs_sel_in),
        .reg_obs_data_out  (reg_obs_data_out),
        .reg_obs_valid_out (reg_obs_valid_out)
    );

    // port: 0/1/2 read ports, 3 obs valid, 4 pending obs bits
    typedef struct {
        int              port;
        logic [XLEN-1:0] exp;
        string           name;
    } chk_t;

    chk_t rd_q[$];
    logic obs_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_rd(input int port, input logic [XLEN-1:0] exp, input string name);
        chk_t c;
        c.port = port;
        c.exp  = exp;
        c.name = name;
        rd_q.push_back(c);
    endtask

    task automatic expect_ports(input logic [XLEN-1:0] exp, input string name);
        expect_rd(0, exp, {name, "_p1"});
        expect_rd(1, exp, {name, "_p2"});
        expect_rd(2, exp, {name, "_src"});
    endtask

    task automatic set_rd(input logic [AW-1:0] a1, input logic [AW-1:0] a2, input logic [AW-1:0] as);
        reg1_in       = a1;
        reg2_in       = a2;
        reg_source_in = as;
    endtask

    task automatic write(input logic [AW-1:0] d, input logic [XLEN-1:0] v);
        reg_dest_in = d;
        data_in     = v;
        reg_wen_in  = 1'b1;
        tick();
        reg_wen_in  = 1'b0;
    endtask

    task automatic push_bits(input logic [XLEN-1:0] w, input int nbits);
        for (int i = XLEN - 1; i >= XLEN - nbits; i--) obs_q.push_back(w[i]);
    endtask

    // Returns in the first data cycle; optionally writes back on the last address edge.
    task automatic send_frame(input logic [AW-1:0] a, input logic do_wr,
                              input logic [AW-1:0] wd, input logic [XLEN-1:0] wv);
        reg_obs_sel_in = 1'b1;
        tick();
        for (int i = AW - 1; i >= 0; i--) begin
            reg_obs_sel_in = a[i];
            if (i == 0 && do_wr) begin
                reg_dest_in = wd;
                data_in     = wv;
                reg_wen_in  = 1'b1;
            end
            tick();
        end
        reg_obs_sel_in = 1'b0;
        reg_wen_in     = 1'b0;
    endtask

    task automatic wait_frame(input string name);
        for (int k = 0; k < XLEN + 8 && obs_q.size() > 0; k++) tick();
        expect_rd(4, '0, {name, "_drained"});
        expect_rd(3, '0, {name, "_idle"});
        tick();
    endtask

    chk_t            m_c;
    logic [XLEN-1:0] m_act;
    logic            m_bit;

    always @(negedge clk) begin
        while (rd_q.size() > 0) begin
            m_c = rd_q.pop_front();
            case (m_c.port)
                0:       m_act = data1_out;
                1:       m_act = data2_out;
                2:       m_act = source_data_out;
                3:       m_act = XLEN'(reg_obs_valid_out);
                4:       m_act = XLEN'(obs_q.size());
                default: m_act = 'x;
            endcase
            n_tests++;
            if (m_act !== m_c.exp) begin
                n_fail++;
                $display("FAIL %s: got %h expected %h", m_c.name, m_act, m_c.exp);
            end
        end
        n_tests++;
        if (reg_obs_valid_out) begin
            if (obs_q.size() == 0) begin
                n_fail++;
                $display("FAIL obs_extra_valid: got valid=1 expected valid=0");
            end else begin
                m_bit = obs_q.pop_front();
                if (reg_obs_data_out !== m_bit) begin
                    n_fail++;
                    $display("FAIL obs_bit: got %b expected %b (%0d left)",
                             reg_obs_data_out, m_bit, obs_q.size());
                end
            end
        end else if (reg_obs_data_out !== 1'b0) begin
            n_fail++;
            $display("FAIL obs_idle_data: got %b expected 0", reg_obs_data_out);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst            = 1'b1;
        reg_wen_in     = 1'b0;
        reg_dest_in    = '0;
        data_in        = '0;
        reg_obs_sel_in = 1'b0;
        set_rd(5'd0, 5'd0, 5'd0);
        tick();
        tick();
        expect_rd(3, '0, "reset_valid");
        rst = 1'b0;

        // reset state: every address on every port reads zero
        for (int a = 0; a < NREGS; a++) begin
            set_rd(AW'(a), AW'((a + 1) % NREGS), AW'((a + 2) % NREGS));
            expect_ports('0, "reset_read");
            tick();
        end

        // write r5, visible next cycle (same cycle only with bypass)
        set_rd(5'd5, 5'd5, 5'd5);
`ifdef REGFILE_BYPASS_EN
        expect_ports(32'hDEADBEEF, "r5_write_cycle");
`else
        expect_ports('0, "r5_write_cycle");
`endif
        write(5'd5, 32'hDEADBEEF);
        expect_ports(32'hDEADBEEF, "r5_after");
        tick();

        // writes to r0 are discarded
        set_rd(5'd0, 5'd0, 5'd5);
        expect_rd(0, '0, "r0_write_cycle");
        write(5'd0, 32'h12345678);
        expect_rd(0, '0, "r0_after_p1");
        expect_rd(1, '0, "r0_after_p2");
        expect_rd(2, 32'hDEADBEEF, "r5_keep");
        tick();

        // full frame on r7
        write(5'd7, 32'h80000001);
        set_rd(5'd7, 5'd3, 5'd0);
        expect_rd(0, 32'h80000001, "r7_read");
        push_bits(32'h80000001, XLEN);
        send_frame(5'd7, 1'b0, '0, '0);
        wait_frame("frame_r7");

        // frame on r3 with write-back on the last address edge: pre-write snapshot
        write(5'd3, 32'hA5A5A5A5);
        push_bits(32'hA5A5A5A5, XLEN);
        send_frame(5'd3, 1'b1, 5'd3, 32'h0);
        set_rd(5'd3, 5'd5, 5'd7);
        expect_rd(0, '0, "r3_after_wr");
        expect_rd(1, 32'hDEADBEEF, "r5_during_frame");
        wait_frame("frame_r3");
        expect_rd(0, '0, "r3_final");
        expect_rd(2, 32'h80000001, "r7_final");
        tick();

        // reset after ten data bits of a r7 frame
        push_bits(32'h80000001, 10);
        send_frame(5'd7, 1'b0, '0, '0);
        repeat (9) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set_rd(5'd5, 5'd7, 5'd1);
        expect_ports('0, "post_rst_regs");
        expect_rd(3, '0, "post_rst_valid");
        expect_rd(4, '0, "post_rst_bits_consumed");
        tick();

        push_bits('0, XLEN);
        send_frame(5'd0, 1'b0, '0, '0);
        wait_frame("frame_r0");

        tick();
        tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
